// File: rtl/wait_ram_pkg.sv
// Shared types and constants for the wait-state RAM: FSM states,
// response-type encoding and the counter load helper.
// Optional feature macro: WAIT_RAM_PARITY_EN (per-byte even parity).
package wait_ram_pkg;

    localparam int WAIT_STATES_MAX = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        RSP_READ  = 2'd0,
        RSP_WRITE = 2'd1,
        RSP_ERR   = 2'd2
    } rsp_e;

    // Value loaded into the 4-bit down-counter when a request is accepted.
    function automatic logic [3:0] wait_load(int n);
        if (n <= 0) begin
            return 4'd0;
        end
        if (n > WAIT_STATES_MAX) begin
            return 4'(WAIT_STATES_MAX - 1);
        end
        return 4'(n - 1);
    endfunction

    // A simultaneous read and write is a conflict and answers with an error.
    function automatic rsp_e decode_req(logic rd, logic wr);
        if (rd && wr) begin
            return RSP_ERR;
        end
        if (wr) begin
            return RSP_WRITE;
        end
        return RSP_READ;
    endfunction

endpackage

// File: rtl/wait_ram_if.sv
// Request/response bus between a requester (master) and wait_ram (slave).
interface wait_ram_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) ();
    logic                  read;
    logic                  write;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     writedata;
    logic [DATA_W/8-1:0]   byteen;
    logic                  ready;
    logic [DATA_W-1:0]     readdata;
    logic                  err;

    modport master (
        output read, write, addr, writedata, byteen,
        input  ready, readdata, err
    );

    modport slave (
        input  read, write, addr, writedata, byteen,
        output ready, readdata, err
    );
endinterface

// File: rtl/wait_ram_array.sv
// Byte-lane storage for wait_ram: single port, synchronous byte-enabled
// write, asynchronous read. Contents are never reset.
// With WAIT_RAM_PARITY_EN defined, each byte carries an even-parity bit
// that is computed on write and checked on the asynchronous read path.
module wait_ram_array #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   byteen,
    output logic [DATA_W-1:0]     rdata,
    output logic                  par_err
);
    localparam int LANES = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

`ifdef WAIT_RAM_PARITY_EN
    logic [LANES-1:0] lane_err;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];

            // Commit this byte only when its enable is set.
            always_ff @(posedge clk) begin
                if (we && byteen[gi]) begin
                    mem[addr] <= wdata[gi*8 +: 8];
                end
            end

            assign rdata[gi*8 +: 8] = mem[addr];

`ifdef WAIT_RAM_PARITY_EN
            logic par_mem [DEPTH];

            // Parity bit travels with its byte: same enable, same edge.
            always_ff @(posedge clk) begin
                if (we && byteen[gi]) begin
                    par_mem[addr] <= ^wdata[gi*8 +: 8];
                end
            end

            assign lane_err[gi] = (^mem[addr]) != par_mem[addr];
`endif
        end
    endgenerate

`ifdef WAIT_RAM_PARITY_EN
    assign par_err = |lane_err;
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: rtl/wait_ram.sv
// Wait-state RAM: answers each request with a one-cycle ready strobe
// WAIT_STATES cycles after acceptance (same cycle when WAIT_STATES = 0).
// Optional feature macro: WAIT_RAM_PARITY_EN (parity errors reported on err).
module wait_ram
    import wait_ram_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic      clk,
    input  logic      reset,
    wait_ram_if.slave bus
);
    localparam int         BE_W      = DATA_W / 8;
    localparam bit         ZERO_WAIT = (WAIT_STATES == 0);
    localparam logic [3:0] CNT_LOAD  = wait_load(WAIT_STATES);

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     be_q, be_d;
    rsp_e                rtype_q, rtype_d;

    logic                ready;
    rsp_e                rsp_type;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [BE_W-1:0]     mem_be;
    logic [DATA_W-1:0]   mem_rdata;
    logic                mem_par_err;

    // Next-state, request latching and response selection.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        rtype_d   = rtype_q;
        ready     = 1'b0;
        rsp_type  = rtype_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_be    = be_q;

        case (state_q)
            IDLE: begin
                if (bus.read || bus.write) begin
                    if (ZERO_WAIT) begin
                        // Zero-wait: answer straight from the live bus.
                        ready     = 1'b1;
                        rsp_type  = decode_req(bus.read, bus.write);
                        mem_addr  = bus.addr;
                        mem_wdata = bus.writedata;
                        mem_be    = bus.byteen;
                    end else begin
                        addr_d  = bus.addr;
                        wdata_d = bus.writedata;
                        be_d    = bus.byteen;
                        rtype_d = decode_req(bus.read, bus.write);
                        cnt_d   = CNT_LOAD;
                        state_d = (WAIT_STATES == 1) ? RESP : WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset aborts any response, including its memory write.
        if (reset) begin
            ready = 1'b0;
        end
    end

    assign mem_we = ready && (rsp_type == RSP_WRITE);

    assign bus.ready    = ready;
    assign bus.readdata = (ready && rsp_type == RSP_READ) ? mem_rdata : '0;
    assign bus.err      = ready && ((rsp_type == RSP_ERR) ||
                                    (rsp_type == RSP_READ && mem_par_err));

    // State register and latched request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rtype_q <= RSP_READ;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rtype_q <= rtype_d;
        end
    end

    wait_ram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .we      (mem_we),
        .addr    (mem_addr),
        .wdata   (mem_wdata),
        .byteen  (mem_be),
        .rdata   (mem_rdata),
        .par_err (mem_par_err)
    );

endmodule

// File: tb/tb_wait_ram.sv
// Directed bench for wait_ram: several instances with different widths
// and wait-state counts, driven one after another from a single sequence.
module tb_wait_ram;
    import wait_ram_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    wait_ram_if #(.DATA_W(8),  .ADDR_W(8)) if0 ();
    wait_ram_if #(.DATA_W(8),  .ADDR_W(8)) if1 ();
    wait_ram_if #(.DATA_W(32), .ADDR_W(8)) if2 ();
    wait_ram_if #(.DATA_W(8),  .ADDR_W(8)) if3 ();
    wait_ram_if #(.DATA_W(8),  .ADDR_W(8)) if4 ();
    wait_ram_if #(.DATA_W(8),  .ADDR_W(8)) if5 ();

    wait_ram #(.DATA_W(8),  .ADDR_W(8), .WAIT_STATES(0)) u0 (.clk(clk), .reset(reset), .bus(if0));
    wait_ram #(.DATA_W(8),  .ADDR_W(8), .WAIT_STATES(3)) u1 (.clk(clk), .reset(reset), .bus(if1));
    wait_ram #(.DATA_W(32), .ADDR_W(8), .WAIT_STATES(2)) u2 (.clk(clk), .reset(reset), .bus(if2));
    wait_ram #(.DATA_W(8),  .ADDR_W(8), .WAIT_STATES(4)) u3 (.clk(clk), .reset(reset), .bus(if3));
    wait_ram #(.DATA_W(8),  .ADDR_W(8), .WAIT_STATES(5)) u4 (.clk(clk), .reset(reset), .bus(if4));
    wait_ram #(.DATA_W(8),  .ADDR_W(8), .WAIT_STATES(1)) u5 (.clk(clk), .reset(reset), .bus(if5));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        {if0.read, if0.write, if0.addr, if0.writedata, if0.byteen} = '0;
        {if1.read, if1.write, if1.addr, if1.writedata, if1.byteen} = '0;
        {if2.read, if2.write, if2.addr, if2.writedata, if2.byteen} = '0;
        {if3.read, if3.write, if3.addr, if3.writedata, if3.byteen} = '0;
        {if4.read, if4.write, if4.addr, if4.writedata, if4.byteen} = '0;
        {if5.read, if5.write, if5.addr, if5.writedata, if5.byteen} = '0;
        repeat (3) tick();

        // ---- reset state ----
        @(negedge clk);
        chk("rst_u1_ready", 64'(if1.ready), 64'h0);
        chk("rst_u1_err", 64'(if1.err), 64'h0);
        chk("rst_u1_rdata", 64'(if1.readdata), 64'h0);
        chk("rst_u2_rdata", 64'(if2.readdata), 64'h0);
        chk("rst_u1_state", 64'(u1.state_q), 64'(IDLE));
        chk("rst_u1_cnt", 64'(u1.cnt_q), 64'h0);
        tick();
        reset = 1'b0;

        // ---- N=0: write A5 to 0x34, read it back ----
        $display("txn u0 write addr=0x34 data=0xA5 be=1");
        if0.write = 1'b1; if0.addr = 8'h34; if0.writedata = 8'hA5; if0.byteen = 1'b1;
        @(negedge clk);
        chk("u0_wr_ready", 64'(if0.ready), 64'h1);
        chk("u0_wr_err", 64'(if0.err), 64'h0);
        chk("u0_wr_rdata", 64'(if0.readdata), 64'h0);
        tick();
        $display("txn u0 write addr=0x34 data=0x5A be=0");
        if0.writedata = 8'h5A; if0.byteen = 1'b0;
        @(negedge clk);
        chk("u0_be0_ready", 64'(if0.ready), 64'h1);
        chk("u0_be0_err", 64'(if0.err), 64'h0);
        tick();
        $display("txn u0 read addr=0x34");
        if0.write = 1'b0; if0.read = 1'b1;
        @(negedge clk);
        chk("u0_rd_ready", 64'(if0.ready), 64'h1);
        chk("u0_rd_data", 64'(if0.readdata), 64'hA5);
        tick();
        if0.read = 1'b0;
        @(negedge clk);
        chk("u0_idle_ready", 64'(if0.ready), 64'h0);
        chk("u0_idle_rdata", 64'(if0.readdata), 64'h0);

        // ---- N=1: write then read, ready one cycle after acceptance ----
        tick();
        $display("txn u5 write addr=0x05 data=0x77");
        if5.write = 1'b1; if5.addr = 8'h05; if5.writedata = 8'h77; if5.byteen = 1'b1;
        for (int k = 0; k <= 1; k++) begin
            @(negedge clk);
            chk("u5_wr_ready", 64'(if5.ready), 64'(k == 1));
            if (k < 1) tick();
        end
        tick();
        $display("txn u5 read addr=0x05");
        if5.write = 1'b0; if5.read = 1'b1;
        for (int k = 0; k <= 1; k++) begin
            @(negedge clk);
            chk("u5_rd_ready", 64'(if5.ready), 64'(k == 1));
            chk("u5_rd_data", 64'(if5.readdata), (k == 1) ? 64'h77 : 64'h0);
            if (k < 1) tick();
        end
        tick();
        if5.read = 1'b0;

        // ---- N=3: write, back-to-back read, exact ready timing ----
        $display("txn u1 write addr=0x20 data=0x3C");
        if1.write = 1'b1; if1.addr = 8'h20; if1.writedata = 8'h3C; if1.byteen = 1'b1;
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            chk("u1_wr_ready", 64'(if1.ready), 64'(k == 3));
            if (k < 3) tick();
        end
        tick();
        $display("txn u1 read addr=0x20 (back-to-back)");
        if1.write = 1'b0; if1.read = 1'b1;
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            chk("u1_rd_ready", 64'(if1.ready), 64'(k == 3));
            chk("u1_rd_data", 64'(if1.readdata), (k == 3) ? 64'h3C : 64'h0);
            if (k < 3) tick();
        end
        tick();
        $display("txn u1 read addr=0x20 (held, accepted after ready)");
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            chk("u1_rd2_ready", 64'(if1.ready), 64'(k == 3));
            if (k < 3) tick();
        end
        tick();
        if1.read = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("u1_quiet_ready", 64'(if1.ready), 64'h0);
            tick();
        end

        // ---- DATA_W=32, N=2: byte-enable merge ----
        $display("txn u2 write addr=0x56 data=0x11223344 be=F");
        if2.write = 1'b1; if2.addr = 8'h56; if2.writedata = 32'h11223344; if2.byteen = 4'hF;
        for (int k = 0; k <= 2; k++) begin
            @(negedge clk);
            chk("u2_wr1_ready", 64'(if2.ready), 64'(k == 2));
            if (k < 2) tick();
        end
        tick();
        $display("txn u2 write addr=0x56 data=0xFFFFFFFF be=5");
        if2.writedata = 32'hFFFFFFFF; if2.byteen = 4'b0101;
        for (int k = 0; k <= 2; k++) begin
            @(negedge clk);
            chk("u2_wr2_ready", 64'(if2.ready), 64'(k == 2));
            if (k < 2) tick();
        end
        tick();
        $display("txn u2 read addr=0x56");
        if2.write = 1'b0; if2.read = 1'b1;
        for (int k = 0; k <= 2; k++) begin
            @(negedge clk);
            chk("u2_rd_ready", 64'(if2.ready), 64'(k == 2));
            chk("u2_rd_data", 64'(if2.readdata), (k == 2) ? 64'h11FF33FF : 64'h0);
            if (k < 2) tick();
        end
        tick();
        if2.read = 1'b0;

        // ---- N=4: read&write conflict ----
        $display("txn u3 write addr=0x40 data=0x66");
        if3.write = 1'b1; if3.addr = 8'h40; if3.writedata = 8'h66; if3.byteen = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            chk("u3_wr_ready", 64'(if3.ready), 64'(k == 4));
            if (k < 4) tick();
        end
        tick();
        $display("txn u3 read+write addr=0x40 data=0x00");
        if3.read = 1'b1; if3.writedata = 8'h00;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            chk("u3_cf_ready", 64'(if3.ready), 64'(k == 4));
            chk("u3_cf_err", 64'(if3.err), 64'(k == 4));
            chk("u3_cf_rdata", 64'(if3.readdata), 64'h0);
            if (k < 4) tick();
        end
        tick();
        $display("txn u3 read addr=0x40");
        if3.write = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            chk("u3_rd_ready", 64'(if3.ready), 64'(k == 4));
            chk("u3_rd_err", 64'(if3.err), 64'h0);
            chk("u3_rd_data", 64'(if3.readdata), (k == 4) ? 64'h66 : 64'h0);
            if (k < 4) tick();
        end
        tick();
        if3.read = 1'b0;

`ifdef WAIT_RAM_PARITY_EN
        // ---- parity: corrupt stored parity at 0x9A ----
        $display("txn u3 write addr=0x9A data=0x3C (parity)");
        if3.write = 1'b1; if3.addr = 8'h9A; if3.writedata = 8'h3C;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            chk("u3_pw_err", 64'(if3.err), 64'h0);
            if (k < 4) tick();
        end
        tick();
        if3.write = 1'b0;
        @(negedge clk);
        u3.u_array.g_lane[0].par_mem[8'h9A] = ~u3.u_array.g_lane[0].par_mem[8'h9A];
        tick();
        $display("txn u3 read addr=0x9A (parity flipped)");
        if3.read = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            chk("u3_par_ready", 64'(if3.ready), 64'(k == 4));
            chk("u3_par_err", 64'(if3.err), 64'(k == 4));
            if (k < 4) tick();
        end
        tick();
        if3.read = 1'b0;
`endif

        // ---- N=5: reset two cycles after a write is accepted ----
        $display("txn u4 write addr=0x12 data=0x81");
        if4.write = 1'b1; if4.addr = 8'h12; if4.writedata = 8'h81; if4.byteen = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            chk("u4_wr_ready", 64'(if4.ready), 64'(k == 5));
            if (k < 5) tick();
        end
        tick();
        $display("txn u4 write addr=0x12 data=0x7E aborted by reset");
        if4.writedata = 8'h7E;
        @(negedge clk);
        chk("u4_ab_ready_t0", 64'(if4.ready), 64'h0);
        tick();
        @(negedge clk);
        chk("u4_ab_ready_t1", 64'(if4.ready), 64'h0);
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("u4_ab_ready_t2", 64'(if4.ready), 64'h0);
        tick();
        reset = 1'b0;
        if4.write = 1'b0;
        @(negedge clk);
        chk("u4_ab_state", 64'(u4.state_q), 64'(IDLE));
        chk("u4_ab_cnt", 64'(u4.cnt_q), 64'h0);
        for (int k = 0; k < 5; k++) begin
            chk("u4_ab_noready", 64'(if4.ready), 64'h0);
            tick();
            @(negedge clk);
        end
        tick();
        $display("txn u4 read addr=0x12");
        if4.read = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            chk("u4_rd_ready", 64'(if4.ready), 64'(k == 5));
            chk("u4_rd_data", 64'(if4.readdata), (k == 5) ? 64'h81 : 64'h0);
            if (k < 5) tick();
        end
        tick();
        if4.read = 1'b0;

        // ---- memory survives reset ----
        $display("txn u0 read addr=0x34 after reset");
        if0.read = 1'b1; if0.addr = 8'h34;
        @(negedge clk);
        chk("u0_keep_ready", 64'(if0.ready), 64'h1);
        chk("u0_keep_data", 64'(if0.readdata), 64'hA5);
        tick();
        if0.read = 1'b0;
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
